taxi_pcie_us_cfg_ext_vsec: RTL
==============================

TAXI_PCIE_US_CFG_EXT_VSEC -- requirements
Module: taxi_pcie_us_cfg_ext_vsec

Interface
REQ-001 Parameters SHALL be:
- VSEC_REG, 10'h0B0: dword register number of the capability base.
- NEXT_PTR, 12'h000: next-capability byte pointer.
- VSEC_ID, 16'h1DED: vendor-specific ID.
- VSEC_REV, 4'h1: VSEC revision.
- FUNC_NUM, 8'h00: function served.
REQ-002 One clock; reset is asynchronous and active-high. Ports, clock and reset first:
- clk  in  1  clock (PCIe user clock)
- rst  in  1  reset
REQ-003 Config-extension ports from the PCIe hard block:
- cfg_ext_read_received  in  1  read strobe
- cfg_ext_write_received  in  1  write strobe
- cfg_ext_register_number  in  10  dword address
- cfg_ext_function_number  in  8  function
- cfg_ext_write_data  in  32  write data
- cfg_ext_write_byte_enable  in  4  byte enables
- cfg_ext_read_data  out  32  read response data
- cfg_ext_read_data_valid  out  1  read response strobe
REQ-004 Mailbox and scratch ports:
- m_mbox_data  out  32  mailbox word
- m_mbox_valid  out  1  mailbox valid
- m_mbox_ready  in  1  mailbox ready
- scratch  out  32  scratch register value

Function
REQ-005 Register map (offset = register_number - VSEC_REG), valid only when function = FUNC_NUM:
- 0: RO {NEXT_PTR, 4'h1, 16'h000B}
- 1: RO {12'h018, VSEC_REV, VSEC_ID}
- 2: RW scratch
- 3: WO mailbox; reads return the last accepted word
- 4: status; bit0 pending (RO), bit1 overflow (W1C), bits[31:16] accepted-write count (RO)
- 5: RO 32'h0
REQ-006 Every read strobe SHALL produce exactly one read_data_valid pulse, one cycle wide, exactly 1 cycle after the strobe, with registered data.
REQ-007 Reads from an offset outside 0..5 or a non-matching function SHALL return 32'h0 with valid still asserted.
REQ-008 Writes SHALL honour byte enables on scratch; mailbox and status writes SHALL act only when byte_enable[0] is set (whole-word semantics); writes to RO or out-of-range offsets SHALL be ignored.
REQ-009 Mailbox state machine: IDLE -> FULL on a mailbox write; FULL -> IDLE when m_mbox_valid && m_mbox_ready.
REQ-010 m_mbox_valid SHALL equal (state == FULL), and m_mbox_data SHALL be stable while valid && !ready.
REQ-011 A mailbox write in FULL without ready in the same cycle SHALL drop the data and set overflow.
REQ-012 A mailbox write in the same cycle as a ready handshake SHALL load the new word, stay FULL, and leave overflow unchanged.
REQ-013 The accepted-write count SHALL increment on each mailbox word loaded, 16 bits, wrapping 16'hFFFF -> 0.
REQ-014 A W1C write that coincides with an overflow event SHALL leave overflow set (set wins).
REQ-015 Simultaneous read and write strobes SHALL NOT occur; if they do, the write SHALL be performed and the read SHALL be answered with pre-write data.
REQ-016 pending SHALL mirror m_mbox_valid.

Reset
REQ-017 On rst:
- cfg_ext_read_data = 0, cfg_ext_read_data_valid = 0
- m_mbox_valid = 0, m_mbox_data = 0
- scratch = 0, overflow = 0, count = 0, state = IDLE
REQ-018 Reset asserted mid-operation SHALL abort any pending read response and discard the mailbox word, with no valid pulse after release.

Verification
REQ-019 Read reg VSEC_REG with defaults -> data 32'h0001000B, valid 1 cycle after strobe; reg VSEC_REG+1 -> 32'h0181_1DED.
REQ-020 Write 32'hAABBCCDD with be 4'b0101 to scratch after reset -> scratch = 32'h00BB00DD, read back equal.
REQ-021 Two mailbox writes 5'h... 32'h1 then 32'h2 with ready low -> m_mbox_data = 1, overflow = 1, status = 32'h0001_0003; raise ready -> one handshake, valid drops.
REQ-022 Mailbox write in the same cycle as a handshake -> new word presented, count = 2, overflow = 0.
REQ-023 Read at VSEC_REG+9, or at VSEC_REG with function 8'h01 -> data 0, valid pulse present.
REQ-024 Assert rst one cycle after a read strobe -> no valid pulse; all outputs 0.

Source files
------------

// File: rtl/taxi_pcie_us_cfg_ext_vsec.sv
// rtl/taxi_pcie_us_cfg_ext_vsec.sv - PCIe config-extension VSEC with scratch and mailbox registers
//
// Ports:
//   clk, rst                    - PCIe user clock, asynchronous active-high reset
//   cfg_ext_*                   - config-extension read/write requests and read response
//   m_mbox_data/valid/ready     - outbound mailbox word stream (valid/ready handshake)
//   scratch                     - current scratch register value
//
// Register map (dword offset from VSEC_REG, function FUNC_NUM only):
//   0 header, 1 VSEC header, 2 scratch, 3 mailbox, 4 status, 5 zero

module taxi_pcie_us_cfg_ext_vsec #(
    parameter logic [9:0]  VSEC_REG = 10'h0B0,
    parameter logic [11:0] NEXT_PTR = 12'h000,
    parameter logic [15:0] VSEC_ID  = 16'h1DED,
    parameter logic [3:0]  VSEC_REV = 4'h1,
    parameter logic [7:0]  FUNC_NUM = 8'h00
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cfg_ext_read_received,
    input  logic        cfg_ext_write_received,
    input  logic [9:0]  cfg_ext_register_number,
    input  logic [7:0]  cfg_ext_function_number,
    input  logic [31:0] cfg_ext_write_data,
    input  logic [3:0]  cfg_ext_write_byte_enable,
    output logic [31:0] cfg_ext_read_data,
    output logic        cfg_ext_read_data_valid,

    output logic [31:0] m_mbox_data,
    output logic        m_mbox_valid,
    input  logic        m_mbox_ready,
    output logic [31:0] scratch
);

    typedef enum logic {
        MBOX_IDLE = 1'b0,
        MBOX_FULL = 1'b1
    } mbox_state_t;

    mbox_state_t mbox_state;
    logic        overflow;
    logic [15:0] count;

    // Offset wraps for addresses below the base, so a single unsigned
    // compare rejects both sides of the window.
    logic [9:0]  offset;
    logic        hit;
    logic        wr_hit;
    logic        handshake;
    logic        mbox_wr;
    logic        ovf_set;
    logic        ovf_clr;
    logic [31:0] rd_mux;

    assign offset    = cfg_ext_register_number - VSEC_REG;
    assign hit       = (cfg_ext_function_number == FUNC_NUM) && (offset <= 10'd5);
    assign wr_hit    = cfg_ext_write_received && hit;

    assign m_mbox_valid = (mbox_state == MBOX_FULL);
    assign handshake    = m_mbox_valid && m_mbox_ready;

    // Mailbox and status act on whole words, gated by the low byte enable.
    assign mbox_wr = wr_hit && (offset == 10'd3) && cfg_ext_write_byte_enable[0];
    assign ovf_set = mbox_wr && m_mbox_valid && !m_mbox_ready;
    assign ovf_clr = wr_hit && (offset == 10'd4) && cfg_ext_write_byte_enable[0]
                     && cfg_ext_write_data[1];

    // Read data is taken from state before any same-cycle write lands.
    always_comb begin
        rd_mux = 32'h0;
        if (hit) begin
            case (offset)
                10'd0:   rd_mux = {NEXT_PTR, 4'h1, 16'h000B};
                10'd1:   rd_mux = {12'h018, VSEC_REV, VSEC_ID};
                10'd2:   rd_mux = scratch;
                10'd3:   rd_mux = m_mbox_data;
                10'd4:   rd_mux = {count, 14'h0, overflow, m_mbox_valid};
                default: rd_mux = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ext_read_data       <= 32'h0;
            cfg_ext_read_data_valid <= 1'b0;
        end else begin
            cfg_ext_read_data_valid <= cfg_ext_read_received;
            if (cfg_ext_read_received) begin
                cfg_ext_read_data <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch <= 32'h0;
        end else if (wr_hit && (offset == 10'd2)) begin
            for (int i = 0; i < 4; i++) begin
                if (cfg_ext_write_byte_enable[i]) begin
                    scratch[i*8 +: 8] <= cfg_ext_write_data[i*8 +: 8];
                end
            end
        end
    end

    // Mailbox FSM: a write is accepted when the slot is empty or is being
    // drained in the same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mbox_state  <= MBOX_IDLE;
            m_mbox_data <= 32'h0;
            count       <= 16'h0;
        end else begin
            case (mbox_state)
                MBOX_IDLE: begin
                    if (mbox_wr) begin
                        m_mbox_data <= cfg_ext_write_data;
                        count       <= count + 16'd1;
                        mbox_state  <= MBOX_FULL;
                    end
                end
                MBOX_FULL: begin
                    if (mbox_wr && m_mbox_ready) begin
                        m_mbox_data <= cfg_ext_write_data;
                        count       <= count + 16'd1;
                    end else if (handshake) begin
                        mbox_state <= MBOX_IDLE;
                    end
                end
                default: mbox_state <= MBOX_IDLE;
            endcase
        end
    end

    // Set wins over a coincident write-one-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
